// File: rtl/fir_tcdm_responder_if.sv
// fir_tcdm_responder_if: request/response bundle between the streamer's
// MP master ports and the behavioural TCDM responder.
//
// Handshake: a master raises req[p] together with add/wen/be/data and holds
// them stable until gnt[p] is seen high in the same cycle; the transfer
// happens at that clock edge. Reads return r_data[p] with r_valid[p] high for
// exactly the one cycle after the granting edge. There is no back-pressure on
// the response path.
interface fir_tcdm_responder_if #(
   parameter int MP         = 3,
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32
);
   logic [MP-1:0]                    req;
   logic [MP-1:0]                    gnt;
   logic [MP-1:0][ADDR_WIDTH-1:0]    add;
   logic [MP-1:0]                    wen;
   logic [MP-1:0][DATA_WIDTH/8-1:0]  be;
   logic [MP-1:0][DATA_WIDTH-1:0]    data;
   logic [MP-1:0][DATA_WIDTH-1:0]    r_data;
   logic [MP-1:0]                    r_valid;

   modport master (output req, add, wen, be, data,
                   input  gnt, r_data, r_valid);

   modport slave  (input  req, add, wen, be, data,
                   output gnt, r_data, r_valid);
endinterface

// File: rtl/fir_tcdm_responder.sv
// fir_tcdm_responder: behavioural single-bank TCDM that serves MP master ports.
// Round-robin arbitration grants at most one request per cycle; reads return
// data one cycle after the grant; granted reads/writes are counted.
// Optional stall injection: define FIR_TCDM_RESPONDER_STALL_EN to build a
// 16-bit LFSR that suppresses grants on roughly a quarter of the cycles.
module fir_tcdm_responder #(
   parameter int          MP         = 3,
   parameter int          DATA_WIDTH = 32,
   parameter int          ADDR_WIDTH = 32,
   parameter int          MEM_WORDS  = 4096,
   parameter logic [15:0] STALL_SEED = 16'hACE1
) (
   input  logic                clk_i,
   input  logic                rst_i,
   fir_tcdm_responder_if.slave tcdm,
   output logic [31:0]         n_reads_o,
   output logic [31:0]         n_writes_o
);
   localparam int BE_W  = DATA_WIDTH / 8;
   localparam int IDX_W = $clog2(MEM_WORDS);
   localparam int PTR_W = (MP > 1) ? $clog2(MP) : 1;
   localparam logic [PTR_W-1:0] LAST_PORT = PTR_W'(MP - 1);

   // Memory bank: intentionally not reset.
   logic [DATA_WIDTH-1:0]         mem_q [MEM_WORDS];

   logic [PTR_W-1:0]              rr_ptr_q, rr_ptr_d;
   logic [MP-1:0]                 r_valid_q, r_valid_d;
   logic [MP-1:0][DATA_WIDTH-1:0] r_data_q;
   logic [31:0]                   n_reads_q, n_reads_d;
   logic [31:0]                   n_writes_q, n_writes_d;

   logic                          stall;
   logic                          gnt_any;
   logic [PTR_W-1:0]              gnt_idx;
   logic [MP-1:0]                 gnt_vec;
   int                            cand;

   logic                          sel_wen;
   logic [IDX_W-1:0]              sel_widx;

`ifdef FIR_TCDM_RESPONDER_STALL_EN
   logic [15:0] lfsr_q, lfsr_d;

   // Fibonacci LFSR, taps 16,14,13,11; a grant is suppressed when the low two bits are zero
   assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign stall  = (lfsr_q[1:0] == 2'b00);

   // LFSR advances every cycle, independent of traffic
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         lfsr_q <= STALL_SEED;
      end else begin
         lfsr_q <= lfsr_d;
      end
   end
`else
   logic [15:0] unused_seed;
   assign unused_seed = STALL_SEED;
   assign stall       = 1'b0;
`endif

   // Round-robin search from the pointer; no grant while stalled or in reset
   always_comb begin
      gnt_any = 1'b0;
      gnt_idx = rr_ptr_q;
      cand    = 0;
      for (int k = 0; k < MP; k++) begin
         cand = (int'(rr_ptr_q) + k) % MP;
         if (!gnt_any && tcdm.req[cand] && !stall && !rst_i) begin
            gnt_any = 1'b1;
            gnt_idx = PTR_W'(cand);
         end
      end
   end

   // One-hot grant vector from the winning index
   always_comb begin
      gnt_vec = '0;
      for (int i = 0; i < MP; i++) begin
         gnt_vec[i] = gnt_any && (gnt_idx == PTR_W'(i));
      end
   end

   assign sel_wen  = tcdm.wen[gnt_idx];
   assign sel_widx = tcdm.add[gnt_idx][IDX_W+1:2];

   assign tcdm.gnt     = gnt_vec;
   assign tcdm.r_valid = r_valid_q;
   assign tcdm.r_data  = r_data_q;
   assign n_reads_o    = n_reads_q;
   assign n_writes_o   = n_writes_q;

   // Next-state: pointer advance, read-valid pulse and transaction counters
   always_comb begin
      rr_ptr_d   = rr_ptr_q;
      r_valid_d  = '0;
      n_reads_d  = n_reads_q;
      n_writes_d = n_writes_q;
      if (gnt_any) begin
         rr_ptr_d = (gnt_idx == LAST_PORT) ? '0 : gnt_idx + PTR_W'(1);
         if (sel_wen) begin
            r_valid_d[gnt_idx] = 1'b1;
            n_reads_d          = n_reads_q + 32'd1;
         end else begin
            n_writes_d = n_writes_q + 32'd1;
         end
      end
   end

   // Control and response registers; read data holds while r_valid is low
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rr_ptr_q   <= '0;
         r_valid_q  <= '0;
         r_data_q   <= '0;
         n_reads_q  <= '0;
         n_writes_q <= '0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         r_valid_q  <= r_valid_d;
         n_reads_q  <= n_reads_d;
         n_writes_q <= n_writes_d;
         if (gnt_any && sel_wen) begin
            r_data_q[gnt_idx] <= mem_q[sel_widx];
         end
      end
   end

   // Byte-lane write of the granted request into the bank
   always_ff @(posedge clk_i) begin
      if (gnt_any && !sel_wen) begin
         for (int b = 0; b < BE_W; b++) begin
            if (tcdm.be[gnt_idx][b]) begin
               mem_q[sel_widx][8*b +: 8] <= tcdm.data[gnt_idx][8*b +: 8];
            end
         end
      end
   end
endmodule

// File: tb/tb_fir_tcdm_responder.sv
// tb_fir_tcdm_responder: directed and random traffic against fir_tcdm_responder
// with a behavioural model (word array, round-robin rule, expected read queue).
// Build with FIR_TCDM_RESPONDER_STALL_EN defined to exercise stall injection.
module tb_fir_tcdm_responder;
   localparam int MP = 3;
   localparam int DW = 32;
   localparam int AW = 32;
   localparam int MW = 4096;
   localparam int BW = DW / 8;
   localparam int EW = 8 + DW;

   // clock / reset
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   fir_tcdm_responder_if #(.MP(MP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
   logic [31:0] n_reads;
   logic [31:0] n_writes;

   fir_tcdm_responder #(
      .MP(MP), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MEM_WORDS(MW), .STALL_SEED(16'hACE1)
   ) dut (
      .clk_i(clk), .rst_i(rst), .tcdm(bus), .n_reads_o(n_reads), .n_writes_o(n_writes)
   );

   int vectors     = 0;
   int miscompares = 0;

   function automatic void chk(string name, logic [127:0] act, logic [127:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endfunction

   function automatic void to_fail(string name);
      vectors++;
      miscompares++;
      $display("FAIL %s: bound expired waiting for the DUT", name);
   endfunction

   // reference model state
   logic [DW-1:0] ref_mem [MW];
   logic [DW-1:0] m_rdata [MP];
   logic [EW-1:0] exp_q[$];
   int            gnt_log[$];
   int            rv_cnt [MP];
   int            m_ptr = 0;
   logic [31:0]   m_reads = '0;
   logic [31:0]   m_writes = '0;
   logic [MP-1:0] gnt_smp = '0;
   logic [MP-1:0] auto_mask = '0;
   logic          rand_en = 1'b0;

   // scoreboard / monitor on the falling edge
   always @(negedge clk) begin : monitor
      int            winner;
      int            widx;
      int            rp;
      logic [EW-1:0] e;
      logic [MP-1:0] exp_rv;
      logic [MP-1:0] exp_g;
      if (rst) begin
         chk("rst_gnt", bus.gnt, 0);
         chk("rst_rvalid", bus.r_valid, 0);
         chk("rst_rdata", bus.r_data, 0);
         chk("rst_nreads", n_reads, 0);
         chk("rst_nwrites", n_writes, 0);
         exp_q.delete();
         gnt_log.delete();
         m_ptr    = 0;
         m_reads  = '0;
         m_writes = '0;
         gnt_smp  = '0;
         for (int p = 0; p < MP; p++) begin
            m_rdata[p] = '0;
            rv_cnt[p]  = 0;
         end
      end else begin
         chk("n_reads", n_reads, m_reads);
         chk("n_writes", n_writes, m_writes);
         exp_rv = '0;
         if (exp_q.size() > 0) begin
            e          = exp_q.pop_front();
            rp         = int'(e[EW-1:DW]);
            exp_rv[rp] = 1'b1;
            m_rdata[rp] = e[DW-1:0];
         end
         chk("r_valid", bus.r_valid, exp_rv);
         for (int p = 0; p < MP; p++) begin
            chk($sformatf("r_data%0d", p), bus.r_data[p], m_rdata[p]);
            if (bus.r_valid[p]) rv_cnt[p]++;
         end
         winner = -1;
         for (int k = 0; k < MP; k++) begin
            if (winner < 0 && bus.req[(m_ptr + k) % MP]) winner = (m_ptr + k) % MP;
         end
         exp_g = (winner >= 0) ? (MP'(1) << winner) : '0;
`ifdef FIR_TCDM_RESPONDER_STALL_EN
         if (bus.gnt != '0 || winner < 0) chk("gnt", bus.gnt, exp_g);
`else
         chk("gnt", bus.gnt, exp_g);
`endif
         gnt_smp = bus.gnt;
         if (winner >= 0 && bus.gnt != '0) begin
            gnt_log.push_back(winner);
            m_ptr = (winner + 1) % MP;
            widx  = int'((bus.add[winner] / 4) % MW);
            if (bus.wen[winner]) begin
               exp_q.push_back({8'(winner), ref_mem[widx]});
               m_reads++;
            end else begin
               for (int b = 0; b < BW; b++) begin
                  if (bus.be[winner][b]) ref_mem[widx][8*b +: 8] = bus.data[winner][8*b +: 8];
               end
               m_writes++;
            end
         end
      end
   end

   // driver tasks
   function automatic logic [AW-1:0] rand_addr();
      logic [AW-1:0] a;
      a = ($urandom() & 32'hFFFF_C000) | AW'($urandom_range(0, 63) * 4) | AW'($urandom_range(0, 3));
      return a;
   endfunction

   task automatic arm(int p, logic wen, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] d);
      bus.req[p]  = 1'b1;
      bus.wen[p]  = wen;
      bus.add[p]  = a;
      bus.be[p]   = be;
      bus.data[p] = d;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      for (int p = 0; p < MP; p++) begin
         if (bus.req[p] && gnt_smp[p]) bus.req[p] = 1'b0;
         if (!bus.req[p]) begin
            if (auto_mask[p]) begin
               arm(p, 1'b1, rand_addr(), '0, '0);
            end else if (rand_en && $urandom_range(0, 1) == 1) begin
               if ($urandom_range(0, 1) == 1) arm(p, 1'b1, rand_addr(), '0, '0);
               else arm(p, 1'b0, rand_addr(), BW'($urandom()), $urandom());
            end
         end
      end
   endtask

   task automatic post(int p, logic wen, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] d);
      int n = 0;
      while (bus.req[p] && n < 100) begin
         step();
         n++;
      end
      if (bus.req[p]) to_fail("post_slot");
      arm(p, wen, a, be, d);
   endtask

   task automatic wait_served(int p, string name);
      int n = 0;
      do begin
         step();
         n++;
      end while (bus.req[p] && n < 100);
      if (bus.req[p]) to_fail(name);
   endtask

   task automatic write_word(int p, logic [AW-1:0] a, logic [BW-1:0] be, logic [DW-1:0] d);
      post(p, 1'b0, a, be, d);
      wait_served(p, "write_grant");
   endtask

   task automatic expect_read(int p, logic [AW-1:0] a, logic [DW-1:0] exp, string name);
      post(p, 1'b1, a, '0, '0);
      wait_served(p, {name, "_grant"});
      chk({name, "_rvalid"}, bus.r_valid[p], 1);
      chk({name, "_rdata"}, bus.r_data[p], exp);
   endtask

   task automatic do_reset();
      rst       = 1'b1;
      bus.req   = '0;
      auto_mask = '0;
      rand_en   = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   // stimulus
   initial begin : main
      int n;
      bus.req  = '0;
      bus.wen  = '0;
      bus.add  = '0;
      bus.be   = '0;
      bus.data = '0;
      do_reset();

      // give words 0..63 known contents (memory survives later resets)
      for (int w = 0; w < 64; w++) write_word(w % MP, AW'(w * 4), '1, $urandom());

      // single write then read
      do_reset();
      write_word(0, 32'h100, 4'hF, 32'hDEADBEEF);
      expect_read(0, 32'h100, 32'hDEADBEEF, "wr_rd");
      chk("wr_rd_nwrites", n_writes, 1);
      chk("wr_rd_nreads", n_reads, 1);

      // byte enables, including an all-zero mask
      write_word(0, 32'h40, 4'hF, 32'h11223344);
      write_word(0, 32'h40, 4'b0101, 32'hAABBCCDD);
      expect_read(0, 32'h40, 32'h11BB33DD, "be_mix");
      write_word(2, 32'h40, 4'b0000, 32'hFFFFFFFF);
      expect_read(1, 32'h40, 32'h11BB33DD, "be_zero");
      chk("be_nwrites", n_writes, 4);

      // address wrap modulo MEM_WORDS*4
      write_word(1, 32'h4004, 4'hF, 32'h5A5A5A5A);
      expect_read(2, 32'h0004, 32'h5A5A5A5A, "wrap");

      // round-robin fairness from reset
      do_reset();
      auto_mask = '1;
      for (int p = 0; p < MP; p++) arm(p, 1'b1, rand_addr(), '0, '0);
      repeat (9) step();
      auto_mask = '0;
      bus.req   = '0;
      repeat (2) step();
      chk("rr_nreads", n_reads, 9);
      chk("rr_grants", gnt_log.size(), 9);
      for (int i = 0; i < 9; i++) begin
         chk($sformatf("rr_order%0d", i), (i < gnt_log.size()) ? gnt_log[i] : -1, i % MP);
      end
      for (int p = 0; p < MP; p++) chk($sformatf("rr_rvalid%0d", p), rv_cnt[p], 3);

      // reset asserted in the cycle a read is granted
      auto_mask = '1;
      for (int p = 0; p < MP; p++) arm(p, 1'b1, rand_addr(), '0, '0);
      step();
      step();
      @(negedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_rvalid", bus.r_valid, 0);
      chk("mid_rst_nreads", n_reads, 0);
      chk("mid_rst_nwrites", n_writes, 0);
      step();
      rst = 1'b0;
      step();
      step();
      auto_mask = '0;
      bus.req   = '0;
      step();
      chk("mid_rst_first_gnt", (gnt_log.size() > 0) ? gnt_log[0] : -1, 0);

      // random mixed traffic on all ports
      rand_en = 1'b1;
      repeat (1500) step();
      rand_en = 1'b0;
      bus.req = '0;
      repeat (3) step();

      // sustained reads on port 1
      do_reset();
      auto_mask = 3'b010;
      arm(1, 1'b1, rand_addr(), '0, '0);
      n = 0;
      while (m_reads < 1000 && n < 4000) begin
         step();
         n++;
      end
      auto_mask = '0;
      bus.req   = '0;
      if (m_reads < 1000) to_fail("sustained_reads");
      step();
      step();
      chk("sustained_nreads", n_reads, 1000);
`ifdef FIR_TCDM_RESPONDER_STALL_EN
      chk("stall_cycles_in_range", (n >= 1200 && n <= 1500), 1);
`else
      chk("sustained_cycles", n, 1000);
`endif

      // final report
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule

// File: doc/fir_tcdm_responder.md
# fir_tcdm_responder

Behavioural TCDM responder that serves the streamer's MP master ports in FIR testbenches, standing in for the cluster TCDM. It arbitrates all ports round-robin onto a single word-addressed memory bank. It grants at most one request per cycle and returns read data with fixed one-cycle latency. It also counts serviced transactions so the bench can check the load/store traffic of a FIR job.

## Interface
- MP, 3, number of TCDM ports served (matches the accelerator's master port count)
- DATA_WIDTH, 32, word width in bits; multiple of 8
- ADDR_WIDTH, 32, byte address width
- MEM_WORDS, 4096, bank depth in words; power of two
- STALL_SEED, 16'hACE1, LFSR reset value; used only with stall injection
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  MP  per-port request
- gnt_o  out  MP  per-port grant; one-hot or zero
- add_i  in  MP×ADDR_WIDTH  per-port byte address
- wen_i  in  MP  1 = read, 0 = write
- be_i  in  MP×DATA_WIDTH/8  byte enables for writes
- data_i  in  MP×DATA_WIDTH  write data
- r_data_o  out  MP×DATA_WIDTH  read data, registered
- r_valid_o  out  MP  read data valid, one-cycle pulse
- n_reads_o  out  32  count of granted reads
- n_writes_o  out  32  count of granted writes

## Operation
- Reset drives these values:
  - gnt_o, r_valid_o, r_data_o: 0.
  - Both counters: 0.
  - Round-robin pointer: 0.
  - LFSR: STALL_SEED.
  - Memory contents are not reset.
- Arbitration is combinational over req_i:
  - Search starts at the pointer index, ascending with wrap modulo MP.
  - The first requesting port is granted.
  - After any grant, the pointer becomes (granted index + 1) mod MP.
  - With no grant, the pointer holds.
- Word index = add_i[$clog2(MEM_WORDS)+1:2].
  - Bits [1:0] are ignored.
  - Upper bits are ignored, so addresses wrap modulo MEM_WORDS×4 bytes.
- Granted write (wen=0):
  - At the granting edge, each byte lane with be=1 is updated from data_i.
  - Lanes with be=0 keep their value.
  - No r_valid is produced.
  - be all-zero is legal: it is counted as a write, and memory is unchanged.
- Granted read (wen=1):
  - At the granting edge, r_data_o[p] is loaded with the word and r_valid_o[p] is set.
  - r_valid_o[p] clears on the next edge unless port p is granted a read again.
  - r_data_o[p] holds its last value while r_valid is low.
- Read after write:
  - A read granted the cycle after a write to the same word returns the new data.
  - No same-cycle hazard exists, because only one grant is issued per cycle.
- Counters increment by 1 on each granted read or write.
  - Both are 32-bit and wrap from 0xFFFFFFFF to 0.
- Requestor rule: req, add, wen, be and data are held stable until gnt.
  - The responder does not check this rule.
  - A request withdrawn before grant is simply not served.
- Reset asserted mid-operation:
  - Any pending r_valid is dropped immediately (asynchronous reset).
  - Arbitration restarts from port 0.

## Timing
- gnt_o is combinational from req_i in the same cycle (zero-latency grant when not stalled).
- Read latency is exactly 1 cycle: grant at edge N, so r_valid_o/r_data_o are valid during cycle N+1.
- Throughput is one transaction per cycle in aggregate.
  - With all MP ports requesting continuously, each port is granted exactly once every MP cycles.
- Back-to-back reads on one port produce a continuous r_valid with a new word each cycle.
- The counters are updated at the granting edge, so they are visible in the following cycle.

## Configuration
- FIR_TCDM_RESPONDER_STALL_EN defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
  - When lfsr[1:0]==2'b00, no grant is issued that cycle (about 25% stall).
  - The round-robin pointer holds during a stalled cycle.
  - Read latency after grant is unchanged.
- FIR_TCDM_RESPONDER_STALL_EN undefined:
  - No LFSR is built and no stalls are injected.
  - Every cycle with at least one request issues a grant.

## Test plan
- Single write then read:
  - Stimulus: port 0 writes 0xDEADBEEF to 0x100 (be=4'hF), then port 0 reads 0x100.
  - Required response: gnt same cycle each time; r_valid[0] one cycle after the read grant; r_data=0xDEADBEEF; n_writes=1, n_reads=1.
- Byte enables:
  - Stimulus: word 0x40 is written to 0x11223344, then 0xAABBCCDD with be=4'b0101, then the word is read.
  - Required response: read returns 0x11BB33DD.
- Round-robin fairness:
  - Stimulus: MP=3, all ports issue continuous reads for 9 cycles from reset.
  - Required response: grant order 0,1,2,0,1,2,0,1,2; each r_valid pulses 3 times; n_reads=9.
- Address wrap:
  - Stimulus: MEM_WORDS=4096; write 0x5A5A5A5A to byte address 0x4004, then read 0x0004.
  - Required response: read returns 0x5A5A5A5A.
- Reset mid-read:
  - Stimulus: rst_i is asserted in the cycle a read is granted.
  - Required response: r_valid never pulses, the counters read 0, and the next grant goes to port 0.
- Stall injection:
  - Stimulus: with FIR_TCDM_RESPONDER_STALL_EN defined, port 1 issues 1000 reads under a continuous request.
  - Required response: each r_valid exactly 1 cycle after its gnt; total cycles between 1200 and 1500; n_reads=1000.
